dac_spi_multi: RTL and testbench

//  APB-programmable SPI write controller for up to NUM_CS daisy-less DACs (AD53x8 family and similar).

---
 rtl/dac_spi_multi_if.sv | 24 ++
 rtl/dac_spi_multi.sv | 248 ++++++++++++++++++++++++
 tb/tb_dac_spi_multi.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dac_spi_multi_if.sv
// APB slave bus bundle for dac_spi_multi.
// The master modport drives requests; the slave modport returns read data and status.
interface dac_spi_multi_if #(
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] paddr;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [31:0]           pwdata;
    logic [31:0]           prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/dac_spi_multi.sv
// APB-programmed SPI write engine for several DACs, with a TX FIFO and LDAC strobing.
// Defining DAC_SPI_IRQ_EN adds the irq_o port and the IRQ register at 0x10.
//  state | meaning
//  IDLE  | sclk parked at CPOL, waits for EN and a queued word (or a manual LDAC request)
//  LEAD  | cs_n asserted, CS setup time
//  SHIFT | 2*DATA_WIDTH sclk edges, MSB first
//  TRAIL | CS hold after the last edge
//  GAP   | cs_n released, minimum high time, LDAC strobe when due
module dac_spi_multi #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CS     = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int CS_DELAY   = 4,
    parameter int LDAC_PULSE = 2,
    parameter int ADDR_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    dac_spi_multi_if.slave    apb,
    output logic              sclk,
    output logic              mosi,
    output logic [NUM_CS-1:0] cs_n,
    output logic              ldac_o
`ifdef DAC_SPI_IRQ_EN
    ,
    output logic              irq_o
`endif
);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;
    localparam int EW      = $clog2(2 * DATA_WIDTH);
    localparam int GAP_LEN = (CS_DELAY > LDAC_PULSE) ? CS_DELAY : LDAC_PULSE;
    localparam int TW      = $clog2(GAP_LEN + 256);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] A_CTRL = 'h00, A_STAT = 'h04, A_TX = 'h08,
                                      A_LDAC = 'h0C, A_IRQ = 'h10;

    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

    logic rst_meta, rst_sync_n;
    logic en, cpol, cpha, ldac_lvl, overflow, ldac_req;
    logic [1:0] ldac_mode;
    logic [7:0] clkdiv;
    logic wr, push_req, push, pop, empty, full, busy;
    logic start_frame, start_strobe, ldac_take, ldac_idle, pulse_due;
    logic [DATA_WIDTH+3:0] mem [FIFO_DEPTH];
    logic [DATA_WIDTH+3:0] head;
    logic [DATA_WIDTH-1:0] head_word, shreg;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] level;
    logic [NUM_CS-1:0] cs_sel;
    logic [31:0] rdata;
    state_t state;
    logic [TW-1:0] timer, ldac_cnt;
    logic [EW-1:0] edge_cnt;
    logic f_cpol, f_cpha, ldac_act;
    logic [7:0] f_div;
    logic unused_ok;

    // Release of the internal reset is aligned to clk; assertion stays asynchronous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {rst_sync_n, rst_meta} <= 2'b00;
        else        {rst_sync_n, rst_meta} <= {rst_meta, 1'b1};
    end

    assign wr           = apb.psel & apb.penable & apb.pwrite;
    assign push_req     = wr && (apb.paddr == A_TX);
    assign push         = push_req & ~full;
    assign empty        = (level == '0);
    assign full         = (level == CW'(FIFO_DEPTH));
    assign busy         = (state != IDLE);
    assign head         = mem[rd_ptr];
    assign head_word    = head[DATA_WIDTH-1:0];
    assign start_strobe = (state == IDLE) && ldac_req;
    assign start_frame  = (state == IDLE) && !ldac_req && en && !empty;
    assign pop          = start_frame;
    assign ldac_take    = start_strobe || ((state == TRAIL) && (timer == '0));
    assign ldac_idle    = (ldac_mode == 2'd1 || ldac_mode == 2'd2) ? 1'b1 : ~ldac_lvl;
    assign pulse_due    = ldac_req || (ldac_mode == 2'd1) || ((ldac_mode == 2'd2) && empty);
    assign apb.pready   = 1'b1;
    assign apb.pslverr  = push_req & full;
    assign apb.prdata   = rdata;
    assign unused_ok    = ^apb.pwdata;

    always_comb begin
        cs_sel = '1;
        for (int i = 0; i < NUM_CS; i++)
            if (head[DATA_WIDTH+3:DATA_WIDTH] == 4'(i)) cs_sel[i] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {apb.pwdata[31:28], apb.pwdata[DATA_WIDTH-1:0]};
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + CW'(1);
            else if (pop && !push) level <= level - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            {en, cpol, cpha, ldac_lvl} <= 4'b0;
            ldac_mode <= 2'b0;
            clkdiv    <= 8'b0;
            overflow  <= 1'b0;
            ldac_req  <= 1'b0;
        end else begin
            if (wr && apb.paddr == A_CTRL) begin
                en        <= apb.pwdata[0];
                cpol      <= apb.pwdata[1];
                cpha      <= apb.pwdata[2];
                ldac_mode <= apb.pwdata[4:3];
                ldac_lvl  <= apb.pwdata[5];
                clkdiv    <= apb.pwdata[15:8];
            end
            overflow <= (overflow & ~(wr && apb.paddr == A_STAT && apb.pwdata[3]))
                        | (push_req & full);
            ldac_req <= (ldac_req & ~ldac_take) | (wr && apb.paddr == A_LDAC && apb.pwdata[0]);
        end
    end

`ifdef DAC_SPI_IRQ_EN
    logic irq_wr, irq_done_en, irq_empty_en, irq_done, irq_empty;
    assign irq_wr = wr && (apb.paddr == A_IRQ);

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            {irq_done_en, irq_empty_en, irq_done, irq_empty, irq_o} <= 5'b0;
        end else begin
            if (irq_wr) {irq_empty_en, irq_done_en} <= apb.pwdata[1:0];
            irq_done  <= (irq_done & ~(irq_wr & apb.pwdata[8]))
                         | ((state == GAP) && (timer == '0));
            irq_empty <= (irq_empty & ~(irq_wr & apb.pwdata[9]))
                         | (pop && !push && level == CW'(1));
            irq_o     <= |({irq_empty, irq_done} & {irq_empty_en, irq_done_en});
        end
    end
`endif

    always_comb begin
        rdata = '0;
        case (apb.paddr)
            A_CTRL:  rdata = {16'b0, clkdiv, 2'b0, ldac_lvl, ldac_mode, cpha, cpol, en};
            A_STAT:  rdata = {20'b0, 4'(level), 4'b0, overflow, busy, full, empty};
`ifdef DAC_SPI_IRQ_EN
            A_IRQ:   rdata = {22'b0, irq_empty, irq_done, 6'b0, irq_empty_en, irq_done_en};
`endif
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state    <= IDLE;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            cs_n     <= '1;
            ldac_o   <= 1'b1;
            timer    <= '0;
            ldac_cnt <= '0;
            edge_cnt <= '0;
            shreg    <= '0;
            f_cpol   <= 1'b0;
            f_cpha   <= 1'b0;
            f_div    <= '0;
            ldac_act <= 1'b0;
        end else begin
            ldac_o <= ldac_idle;
            case (state)
                IDLE: begin
                    sclk <= cpol;
                    if (start_strobe) begin
                        state    <= GAP;
                        ldac_o   <= 1'b0;
                        ldac_act <= 1'b1;
                        ldac_cnt <= TW'(LDAC_PULSE - 1);
                        timer    <= TW'(GAP_LEN - 1);
                    end else if (start_frame) begin
                        state  <= LEAD;
                        cs_n   <= cs_sel;
                        f_cpol <= cpol;
                        f_cpha <= cpha;
                        f_div  <= clkdiv;
                        // CPHA=0 presents the MSB now; later bits go out on trailing edges.
                        shreg  <= cpha ? head_word : head_word << 1;
                        mosi   <= cpha ? mosi : head_word[DATA_WIDTH-1];
                        timer  <= TW'(CS_DELAY - 1);
                    end
                end
                LEAD: begin
                    if (timer == '0) begin
                        state    <= SHIFT;
                        timer    <= TW'(f_div);
                        edge_cnt <= '0;
                    end else timer <= timer - 1'b1;
                end
                SHIFT: begin
                    if (timer == '0) begin
                        sclk  <= ~sclk;
                        timer <= TW'(f_div);
                        // Even edge_cnt is a leading edge, odd a trailing edge.
                        if (f_cpha ? !edge_cnt[0] : (edge_cnt[0] && edge_cnt != LAST_EDGE)) begin
                            mosi  <= shreg[DATA_WIDTH-1];
                            shreg <= shreg << 1;
                        end
                        if (edge_cnt == LAST_EDGE) begin
                            state <= TRAIL;
                            timer <= TW'(CS_DELAY - 1);
                        end else edge_cnt <= edge_cnt + 1'b1;
                    end else timer <= timer - 1'b1;
                end
                TRAIL: begin
                    sclk <= f_cpol;
                    if (timer == '0) begin
                        state <= GAP;
                        cs_n  <= '1;
                        if (pulse_due) begin
                            ldac_o   <= 1'b0;
                            ldac_act <= 1'b1;
                            ldac_cnt <= TW'(LDAC_PULSE - 1);
                            timer    <= TW'(GAP_LEN - 1);
                        end else timer <= TW'(CS_DELAY - 1);
                    end else timer <= timer - 1'b1;
                end
                GAP: begin
                    if (ldac_act) begin
                        if (ldac_cnt == '0) ldac_act <= 1'b0;
                        else begin
                            ldac_cnt <= ldac_cnt - 1'b1;
                            ldac_o   <= 1'b0;
                        end
                    end
                    if (timer == '0) state <= IDLE;
                    else timer <= timer - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dac_spi_multi.sv
// Directed bench for dac_spi_multi: APB stimulus, pin monitor and frame scoreboard.
// Exercises the IRQ register as well when DAC_SPI_IRQ_EN is defined.
module tb_dac_spi_multi;
    localparam int NCS = 4;

    logic clk, rst_n;
    logic sclk, mosi, ldac_o;
    logic [NCS-1:0] cs_n;
`ifdef DAC_SPI_IRQ_EN
    logic irq_o;
`endif

    dac_spi_multi_if #(.ADDR_WIDTH(8)) apb_if ();

    dac_spi_multi dut (
        .clk   (clk),
        .rst_n (rst_n),
        .apb   (apb_if),
        .sclk  (sclk),
        .mosi  (mosi),
        .cs_n  (cs_n),
        .ldac_o(ldac_o)
`ifdef DAC_SPI_IRQ_EN
        ,
        .irq_o (irq_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0, total = 0, fails = 0;
    logic tb_cpol = 1'b0, tb_cpha = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] obs[$];
    int rd_idx = 0;

    // Pin monitor: reassembles frames at the sampling edge and measures sclk/LDAC timing.
    int sclk_edges = 0, cs_low_cycles = 0, bad_launch = 0, frames_done = 0;
    int cyc = 0, last_sample_cyc = 0, last_period = 0, bitcnt = 0;
    int ldac_pulses = 0, low_w = 0, last_low_width = 0, frames_at_pulse = 0;
    logic prev_sclk = 1'b0, prev_mosi = 1'b0, prev_ldac = 1'b1;
    logic [15:0] shw = '0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            bitcnt = 0;
            shw    = '0;
        end else begin
            if (cs_n !== 4'hF) cs_low_cycles++;
            if (sclk !== prev_sclk) begin
                sclk_edges++;
                if (cs_n !== 4'hF && sclk === (tb_cpol == tb_cpha)) begin
                    if (mosi !== prev_mosi) bad_launch++;
                    last_period     = cyc - last_sample_cyc;
                    last_sample_cyc = cyc;
                    shw = {shw[14:0], mosi};
                    bitcnt++;
                    if (bitcnt == 16) begin
                        obs.push_back({12'b0, cs_n, shw});
                        frames_done++;
                        bitcnt = 0;
                    end
                end
            end
            if (ldac_o === 1'b0 && prev_ldac === 1'b1) begin
                ldac_pulses++;
                frames_at_pulse = frames_done;
                low_w = 0;
            end
            if (ldac_o === 1'b0) low_w++;
            if (ldac_o === 1'b1 && prev_ldac === 1'b0) last_low_width = low_w;
        end
        prev_sclk = sclk;
        prev_mosi = mosi;
        prev_ldac = ldac_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic err);
        @(posedge clk); #1;
        apb_if.paddr = a; apb_if.pwdata = d; apb_if.pwrite = 1'b1;
        apb_if.psel = 1'b1; apb_if.penable = 1'b0;
        @(posedge clk); #1;
        apb_if.penable = 1'b1;
        #1 err = apb_if.pslverr;
        @(posedge clk); #1;
        apb_if.psel = 1'b0; apb_if.penable = 1'b0; apb_if.pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        apb_if.paddr = a; apb_if.pwrite = 1'b0;
        apb_if.psel = 1'b1; apb_if.penable = 1'b0;
        @(posedge clk); #1;
        apb_if.penable = 1'b1;
        #1 d = apb_if.prdata;
        @(posedge clk); #1;
        apb_if.psel = 1'b0; apb_if.penable = 1'b0;
    endtask

    function automatic logic [31:0] frame_of(input logic [31:0] w);
        logic [3:0] idx;
        logic [NCS-1:0] csx;
        idx = w[31:28];
        csx = (idx < NCS) ? ~(NCS'(1) << idx) : '1;
        return {12'b0, csx, w[15:0]};
    endfunction

    task automatic push_word(input logic [31:0] w);
        logic e;
        apb_write(8'h08, w, e);
        exp_q.push_back(frame_of(w));
    endtask

    task automatic check_frames(input int n, input string tag);
        int t = 0;
        logic [31:0] got, exp;
        while (obs.size() < rd_idx + n && t < 5000) begin
            @(posedge clk);
            t++;
        end
        for (int i = 0; i < n; i++) begin
            exp = exp_q.pop_front();
            if (rd_idx < obs.size()) begin
                got = obs[rd_idx];
                rd_idx++;
            end else got = 'x;
            check(tag, got, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] s;
        int t = 0;
        s = 32'h4;
        while ((s[2] || !s[0]) && t < 500) begin
            apb_read(8'h04, s);
            t++;
        end
        check(tag, {31'b0, s[2]}, 32'h0);
    endtask

    initial begin
        logic [31:0] r;
        logic e, eor;
        int e0, c0, b0, p0, f0, t;

        apb_if.paddr = '0; apb_if.pwdata = '0; apb_if.pwrite = 1'b0;
        apb_if.psel = 1'b0; apb_if.penable = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("rst_cs_n", 32'(cs_n), 32'hF);
        check("rst_pins", {29'b0, sclk, mosi, ldac_o}, 32'h1);
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(posedge clk);
        apb_read(8'h04, r); check("rst_stat", r, 32'h1);
        apb_read(8'h00, r); check("rst_ctrl", r, 32'h0);

        // Mode 0, CLKDIV=1, word A5C3 to chip select 1.
        apb_write(8'h00, 32'h0101, e);
        push_word(32'h1000_A5C3);
        check_frames(1, "frame_a5c3");
        check("period_mode0", last_period, 4);
        wait_idle("idle_a5c3");

        // Out-of-range index: word is clocked but no chip select goes low.
        e0 = sclk_edges; c0 = cs_low_cycles;
        apb_write(8'h08, 32'hF000_1234, e);
        repeat (4) @(posedge clk);
        wait_idle("idle_nocs");
        check("nocs_edges", sclk_edges - e0, 32);
        check("nocs_cs_low", cs_low_cycles - c0, 0);

        // CPOL=1, CPHA=1.
        tb_cpol = 1'b1; tb_cpha = 1'b1;
        apb_write(8'h00, 32'h0107, e);
        repeat (2) @(posedge clk);
        #1 check("cpol1_idle_sclk", {31'b0, sclk}, 32'h1);
        b0 = bad_launch;
        push_word(32'h0000_FFFF);
        push_word(32'h2000_5A3C);
        check_frames(2, "frame_mode3");
        check("mode3_launch_edge", bad_launch - b0, 0);
        check("period_mode3", last_period, 4);
        wait_idle("idle_mode3");

        // Fill with EN=0 to force overflow, then drain.
        tb_cpol = 1'b0; tb_cpha = 1'b0;
        apb_write(8'h00, 32'h0000, e);
        eor = 1'b0;
        for (int i = 0; i < 8; i++) begin
            r = {2'b0, 2'($urandom_range(0, 3)), 12'b0, 16'($urandom_range(0, 65535))};
            apb_write(8'h08, r, e);
            exp_q.push_back(frame_of(r));
            eor |= e;
        end
        check("fill_pslverr", {31'b0, eor}, 32'h0);
        apb_write(8'h08, 32'h0000_DEAD, e);
        check("overflow_pslverr", {31'b0, e}, 32'h1);
        apb_read(8'h04, r); check("stat_full", r, 32'h80A);
        apb_write(8'h04, 32'h8, e);
        apb_read(8'h04, r); check("stat_w1c", r, 32'h802);
        apb_write(8'h00, 32'h0101, e);
        check_frames(8, "frame_drain");
        wait_idle("idle_drain");
        apb_read(8'h04, r); check("stat_drained", r, 32'h1);

        // LDAC batch mode: one strobe after the third frame only.
        apb_write(8'h00, 32'h0110, e);
        repeat (2) @(posedge clk);
        #1 check("mode2_ldac_idle", {31'b0, ldac_o}, 32'h1);
        p0 = ldac_pulses; f0 = frames_done;
        push_word(32'h0000_1111);
        push_word(32'h1000_2222);
        push_word(32'h3000_3333);
        apb_write(8'h00, 32'h0111, e);
        check_frames(3, "frame_batch");
        wait_idle("idle_batch");
        check("batch_pulses", ldac_pulses - p0, 1);
        check("batch_width", last_low_width, 2);
        check("batch_after_frame", frames_at_pulse - f0, 3);

        // Manual LDAC strobe and static level.
        apb_write(8'h00, 32'h0100, e);
        p0 = ldac_pulses;
        apb_write(8'h0C, 32'h1, e);
        repeat (10) @(posedge clk);
        check("manual_pulses", ldac_pulses - p0, 1);
        check("manual_width", last_low_width, 2);
        apb_write(8'h00, 32'h0120, e);
        repeat (2) @(posedge clk);
        #1 check("static_lvl", {31'b0, ldac_o}, 32'h0);

        // Unmapped reads.
        apb_write(8'h14, 32'hFFFF_FFFF, e);
        apb_read(8'h14, r); check("unmapped_14", r, 32'h0);
`ifndef DAC_SPI_IRQ_EN
        apb_write(8'h10, 32'hFFFF_FFFF, e);
        apb_read(8'h10, r); check("irq_reg_absent", r, 32'h0);
`endif

        // Reset in the middle of SHIFT.
        apb_write(8'h00, 32'h0121, e);
        apb_write(8'h08, 32'h2000_1234, e);
        e0 = sclk_edges; t = 0;
        while (sclk_edges - e0 < 5 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("midshift_reached", {31'b0, cs_n !== 4'hF}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_cs_n", 32'(cs_n), 32'hF);
        check("midrst_pins", {29'b0, sclk, mosi, ldac_o}, 32'h1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        apb_read(8'h04, r); check("midrst_stat", r, 32'h1);
        apb_read(8'h00, r); check("midrst_ctrl", r, 32'h0);

`ifdef DAC_SPI_IRQ_EN
        apb_write(8'h00, 32'h0101, e);
        apb_write(8'h10, 32'h1, e);
        #1 check("irq_idle", {31'b0, irq_o}, 32'h0);
        push_word(32'h0000_0F0F);
        check_frames(1, "frame_irq");
        t = 0;
        while (irq_o !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("irq_done", {31'b0, irq_o}, 32'h1);
        check("irq_after_gap", 32'(cs_n), 32'hF);
        apb_read(8'h10, r); check("irq_reg", r, 32'h301);
        apb_write(8'h10, 32'h101, e);
        repeat (2) @(posedge clk);
        #1 check("irq_cleared", {31'b0, irq_o}, 32'h0);
        apb_read(8'h10, r); check("irq_reg_w1c", r, 32'h201);
`endif

        repeat (20) @(posedge clk);
        check("no_extra_frames", obs.size(), rd_idx);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
